// File: rtl/timer_pkg.sv
// Shared types and constants for the HH:MM:SS timer mode/set controller.
package timer_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_t;

  localparam int unsigned NUM_DIGITS = 6;

  // Digit order {h2,h1,m2,m1,s2,s1}; 1 = blank the digit.
  localparam logic [NUM_DIGITS-1:0] MASK_HOUR = 6'b110000;
  localparam logic [NUM_DIGITS-1:0] MASK_MIN  = 6'b001100;
  localparam logic [NUM_DIGITS-1:0] MASK_SEC  = 6'b000011;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_RUN:      next_mode = MODE_SET_HOUR;
      MODE_SET_HOUR: next_mode = MODE_SET_MIN;
      MODE_SET_MIN:  next_mode = MODE_SET_SEC;
      default:       next_mode = MODE_RUN;
    endcase
  endfunction

  function automatic logic [NUM_DIGITS-1:0] field_mask(input mode_t m);
    case (m)
      MODE_SET_HOUR: field_mask = MASK_HOUR;
      MODE_SET_MIN:  field_mask = MASK_MIN;
      MODE_SET_SEC:  field_mask = MASK_SEC;
      default:       field_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button press edge detector with hold-to-repeat timing (initial delay, then period).
module btn_repeat #(
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  input  logic en,
  output logic press,
  output logic rep
);

  localparam int unsigned CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  logic          lvl_r;
  logic          lvl_q;
  logic          armed;
  logic          holding;
  logic          in_dly;
  logic [CW-1:0] cnt;
  logic [CW-1:0] target;

  // armed stays low until a released level is seen, so a button held through
  // reset release never produces a press.
  assign press  = lvl_r & ~lvl_q & armed;
  assign target = in_dly ? CW'(REPEAT_DLY - 1) : CW'(REPEAT_PER - 1);
  assign rep    = en & holding & lvl_r & (cnt == target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_r   <= 1'b0;
      lvl_q   <= 1'b0;
      armed   <= 1'b0;
      holding <= 1'b0;
      in_dly  <= 1'b1;
      cnt     <= '0;
    end else begin
      lvl_r <= lvl;
      lvl_q <= lvl_r;
      armed <= armed | ~lvl;
      if (!en || (!press && (!holding || !lvl_r))) begin
        holding <= 1'b0;
        in_dly  <= 1'b1;
        cnt     <= '0;
      end else if (press) begin
        holding <= 1'b1;
        in_dly  <= 1'b1;
        cnt     <= '0;
      end else if (rep) begin
        in_dly <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/timer_set_ctrl.sv
// Mode/set controller for the HH:MM:SS timer chain: RUN plus hour/min/sec edit modes.
// Optional digit blinking is built when TIMER_BLINK_EN is defined.
module timer_set_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000,
  parameter int unsigned TIMEOUT_S  = 10,
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_en,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       clr_sec,
  output logic [1:0] mode,
  output logic [5:0] blink_mask
);

  localparam int unsigned TCW = $clog2(TIMEOUT_S);

  if (REPEAT_DLY < 2 || REPEAT_PER < 2 || TIMEOUT_S < 2 || BLINK_HALF < 2) begin : g_param_check
    $error("timer_set_ctrl: timing parameters must be >= 2");
  end

  mode_t          mode_q;
  logic           m_r;
  logic           m_q;
  logic           m_armed;
  logic           mode_press;
  logic           inc_press;
  logic           inc_rep;
  logic           rep_en;
  logic           edit;
  logic           activity;
  logic           to_fire;
  logic           inc_evt;
  logic [TCW-1:0] to_cnt;

  assign mode_press = m_r & ~m_q & m_armed;
  assign edit       = (mode_q != MODE_RUN);
  // Deasserting en during a mode press both suppresses the repeat and clears its state.
  assign rep_en     = ((mode_q == MODE_SET_HOUR) || (mode_q == MODE_SET_MIN)) & ~mode_press;

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_inc_rep (
    .clk   (clk),
    .rst   (rst),
    .lvl   (btn_inc),
    .en    (rep_en),
    .press (inc_press),
    .rep   (inc_rep)
  );

  assign activity = mode_press | inc_press | inc_rep;
  assign to_fire  = edit & tick_1hz & ~activity & (to_cnt == TCW'(TIMEOUT_S - 1));
  assign inc_evt  = edit & ~mode_press & (inc_press | inc_rep);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= MODE_RUN;
      m_r      <= 1'b0;
      m_q      <= 1'b0;
      m_armed  <= 1'b0;
      to_cnt   <= '0;
      run_en   <= 1'b0;
      inc_hour <= 1'b0;
      inc_min  <= 1'b0;
      clr_sec  <= 1'b0;
    end else begin
      m_r     <= btn_mode;
      m_q     <= m_r;
      m_armed <= m_armed | ~btn_mode;

      run_en   <= tick_1hz & ~edit;
      inc_hour <= inc_evt & (mode_q == MODE_SET_HOUR);
      inc_min  <= inc_evt & (mode_q == MODE_SET_MIN);
      clr_sec  <= inc_evt & (mode_q == MODE_SET_SEC);

      if (mode_press) begin
        mode_q <= next_mode(mode_q);
      end else if (to_fire) begin
        mode_q <= MODE_RUN;
      end

      if (!edit || activity || to_fire) begin
        to_cnt <= '0;
      end else if (tick_1hz) begin
        to_cnt <= to_cnt + TCW'(1);
      end
    end
  end

  assign mode = mode_q;

`ifdef TIMER_BLINK_EN
  localparam int unsigned BCW = $clog2(BLINK_HALF);

  logic [BCW-1:0] blink_cnt;
  logic           phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (!edit || mode_press || to_fire || inc_evt) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BCW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + BCW'(1);
    end
  end

  assign blink_mask = phase ? field_mask(mode_q) : '0;
`else
  assign blink_mask = '0;
`endif

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Scoreboard bench for timer_set_ctrl: per-cycle expectations from a behavioural model.
module tb_timer_set_ctrl;
  import timer_pkg::*;

  localparam int DLY = 8;
  localparam int PER = 4;
  localparam int TMO = 3;
  localparam int BH  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       run_en;
  logic       inc_hour;
  logic       inc_min;
  logic       clr_sec;
  logic [1:0] mode;
  logic [5:0] blink_mask;

  timer_set_ctrl #(
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER),
    .TIMEOUT_S  (TMO),
    .BLINK_HALF (BH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .run_en     (run_en),
    .inc_hour   (inc_hour),
    .inc_min    (inc_min),
    .clr_sec    (clr_sec),
    .mode       (mode),
    .blink_mask (blink_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       run_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic [1:0] mode;
    logic [5:0] mask;
  } out_t;

  out_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_no = 0;
  int   n_run = 0;
  int   n_hour = 0;
  int   n_min = 0;
  int   n_clr = 0;

  // Reference model state: mode, raw button history, hold start, ticks since activity.
  int step_k = 0;
  int m_mode = 0;
  bit mh1 = 1'b1, mh2 = 1'b1, ih1 = 1'b1, ih2 = 1'b1;
  int rep_start = -1;
  int tcount = 0;
`ifdef TIMER_BLINK_EN
  int blink_ref = 0;

  function automatic logic [5:0] mask_of(input int m);
    case (m)
      1:       mask_of = MASK_HOUR;
      2:       mask_of = MASK_MIN;
      3:       mask_of = MASK_SEC;
      default: mask_of = 6'b0;
    endcase
  endfunction
`endif

  function automatic void model_step(input bit r, input bit t, input bit bm, input bit bi);
    out_t e;
    bit   mp, ip, rep, en, fire, evt;
    int   mb, nm, d;
    e = '0;
    step_k++;
    if (r) begin
      m_mode = 0; mh1 = 1'b1; mh2 = 1'b1; ih1 = 1'b1; ih2 = 1'b1;
      rep_start = -1; tcount = 0;
`ifdef TIMER_BLINK_EN
      blink_ref = step_k;
`endif
      exp_q.push_back(e);
      return;
    end
    mp = mh1 && !mh2;
    ip = ih1 && !ih2;
    mb = m_mode;
    en = (mb == 1 || mb == 2) && !mp;
    rep = 1'b0;
    if (en && rep_start >= 0 && ih1) begin
      d = step_k - rep_start;
      rep = (d >= DLY) && (((d - DLY) % PER) == 0);
    end
    if (!en) rep_start = -1;
    else if (ip) rep_start = step_k;
    else if (!ih1) rep_start = -1;
    fire = (mb != 0) && t && !(mp || ip || rep) && (tcount == TMO - 1);
    evt  = (mb != 0) && !mp && (ip || rep);
    nm   = mp ? (mb + 1) % 4 : (fire ? 0 : mb);
    if (mb == 0 || mp || ip || rep || fire) tcount = 0;
    else if (t) tcount++;
    e.run_en   = t && (mb == 0);
    e.inc_hour = evt && (mb == 1);
    e.inc_min  = evt && (mb == 2);
    e.clr_sec  = evt && (mb == 3);
    e.mode     = 2'(nm);
`ifdef TIMER_BLINK_EN
    if (mb == 0 || mp || fire || evt) blink_ref = step_k;
    e.mask = ((((step_k - blink_ref) / BH) % 2) == 1) ? mask_of(nm) : 6'b0;
`endif
    m_mode = nm;
    mh2 = mh1; mh1 = bm;
    ih2 = ih1; ih1 = bi;
    exp_q.push_back(e);
  endfunction

  // Monitor: compare every presented output cycle against the head of the queue.
  initial begin
    out_t e;
    out_t got;
    forever begin
      @(posedge clk);
      #2;
      cyc_no++;
      if (inc_hour === 1'b1) n_hour++;
      if (inc_min === 1'b1) n_min++;
      if (clr_sec === 1'b1) n_clr++;
      if (run_en === 1'b1) n_run++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {run_en, inc_hour, inc_min, clr_sec, mode, blink_mask};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs cyc=%0d got run_en=%b inc_hour=%b inc_min=%b clr_sec=%b mode=%0d mask=%b expected run_en=%b inc_hour=%b inc_min=%b clr_sec=%b mode=%0d mask=%b",
                   cyc_no, got.run_en, got.inc_hour, got.inc_min, got.clr_sec, got.mode, got.mask,
                   e.run_en, e.inc_hour, e.inc_min, e.clr_sec, e.mode, e.mask);
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit t, input bit bm, input bit bi);
    @(negedge clk);
    rst = r; tick_1hz = t; btn_mode = bm; btn_inc = bi;
    model_step(r, t, bm, bi);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_mode();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
  endtask

  task automatic check_cnt(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  initial begin
    int  s_run, s_hour, s_min, s_clr;
    bit  bm_lvl, bi_lvl, r;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // RUN: ticks pass straight through as run_en.
    s_run = n_run;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    idle(2);
    check_cnt("run_en_count", n_run - s_run, 5);

    // Mode cycling with a tick in each mode (frozen while editing).
    s_run = n_run;
    for (int i = 0; i < 3; i++) begin
      press_mode();
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    press_mode();
    check_cnt("run_en_in_edit", n_run - s_run, 0);

    // SET_HOUR: hold inc 20 cycles -> press pulse plus three repeats.
    press_mode();
    s_hour = n_hour;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);
    check_cnt("inc_hour_repeat", n_hour - s_hour, 4);

    // SET_SEC: hold inc 20 cycles -> exactly one clr_sec.
    press_mode();
    press_mode();
    s_hour = n_hour; s_min = n_min; s_clr = n_clr;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);
    check_cnt("clr_sec_once", n_clr - s_clr, 1);
    check_cnt("no_inc_in_sec", (n_hour - s_hour) + (n_min - s_min), 0);

    // Timeout from SET_MIN, then a restart of the count by an inc press.
    press_mode();
    press_mode();
    press_mode();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
    end
    press_mode();
    press_mode();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
    end

    // Simultaneous mode+inc in SET_HOUR, blink period, then reset mid-edit.
    press_mode();
    s_hour = n_hour;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    idle(24);
    check_cnt("no_inc_on_mode_press", n_hour - s_hour, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    // Buttons held through reset release must not register as presses.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);

    // Randomised traffic.
    bm_lvl = 1'b0; bi_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) bi_lvl = !bi_lvl;
      if ($urandom_range(0, 29) == 0) bm_lvl = !bm_lvl;
      r = ($urandom_range(0, 999) == 0);
      cyc(r, ($urandom_range(0, 15) == 0), bm_lvl, bi_lvl);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
